pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the decode stage and drives stall, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken branches and jumps, and multi-cycle data-memory waits, and halts the core on a memory timeout. It also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before the core halts.
- CNT_W, 32: performance counter width.
- i_clk  in  1  core clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_id_rs1_addr  in  5  rs1 of the instruction in decode.
- i_id_rs2_addr  in  5  rs2 of the instruction in decode.
- i_idex_rd_addr  in  5  rd held in the ID/EX register.
- i_idex_ctrl  in  16  ID/EX control bundle: {REG_we[15], SRC_A[14], SRC_B[13:12], ALU[11:8], BRANCH[7:5], MemtoReg_SRC[4], MEM_we[3], MEM_op[2:0]}.
- i_ex_redirect  in  1  EX resolved a taken branch, jal or jalr.
- i_mem_req  in  1  MEM stage has a data-memory access this cycle.
- i_mem_ack  in  1  data memory completes the access this cycle.
- o_pc_stall  out  1  hold the PC.
- o_ifid_stall  out  1  hold IF/ID.
- o_ifid_flush  out  1  load a NOP into IF/ID.
- o_idex_stall  out  1  hold ID/EX.
- o_idex_flush  out  1  load an all-zero bubble into ID/EX.
- o_exmem_stall  out  1  hold EX/MEM.
- o_memwb_flush  out  1  load a bubble into MEM/WB.
- o_mem_err  out  1  sticky memory-timeout flag.
- o_state  out  2  current FSM state.
- o_stall_cnt  out  CNT_W  count of cycles with o_pc_stall high.
- o_flush_cnt  out  CNT_W  count of cycles with o_ifid_flush high.

## Operation
**Hazard terms (combinational)**
- load_in_ex = i_idex_ctrl[15] & i_idex_ctrl[4] & ~i_idex_ctrl[3].
- load_use = load_in_ex & (rd != 0) & (rd == rs1 | rd == rs2). This is conservative: rs2 is compared for every format.
- mem_busy = i_mem_req & ~i_mem_ack.

**FSM states**
- RUN = 0, MEM_WAIT = 1, HALT = 2.

**Control outputs by priority (highest first)**
1. **HALT:** all stall outputs = 1. o_memwb_flush = 1. Both flush outputs for IF/ID and ID/EX = 0.
2. **mem_busy (in RUN or MEM_WAIT):**
   - o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall = 1.
   - o_memwb_flush = 1.
   - o_ifid_flush and o_idex_flush = 0.
   - i_ex_redirect is ignored while mem_busy holds. EX is frozen, so the redirect stays asserted and is applied on release.
3. **i_ex_redirect:** o_ifid_flush = 1 and o_idex_flush = 1. No stalls.
4. **load_use:** o_pc_stall = 1, o_ifid_stall = 1, o_idex_flush = 1.
5. **Otherwise:** all outputs = 0.

**FSM transitions**
- RUN → MEM_WAIT when mem_busy.
- MEM_WAIT → RUN when i_mem_ack. The release cycle has no memory stall.
- MEM_WAIT → HALT when wait_cnt == MEM_TIMEOUT-1 and i_mem_ack = 0. o_mem_err is set in the same transition.
- HALT holds until i_reset.

**Counters**
- wait_cnt clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT.
- o_stall_cnt and o_flush_cnt saturate at all-ones and do not wrap.

## Timing
- All control outputs are Mealy: they respond in the same cycle as their inputs. State, wait_cnt, o_mem_err and both performance counters are registered.
- Reset values:
  - state = RUN, wait_cnt = 0, o_mem_err = 0, both counters = 0.
  - All control outputs are forced to 0 during the reset cycle.
- A load-use stall lasts exactly 1 cycle. The next cycle ID/EX holds a bubble, so the hazard clears.
- A redirect costs 2 bubbles with no extra stall.
- A memory access acked in the same cycle as its request causes no stall and no state change.
- A memory wait of N cycles produces N stall cycles.
- Reset asserted mid-wait or in HALT returns to RUN on the next edge. o_mem_err clears.
- Redirect together with load_use: the redirect wins, because the instruction in decode is on the wrong path.

## Structure
- Add to the shared defines:
  - FSM state encodings.
  - The control-bundle bit positions (REG_we, MemtoReg_SRC, MEM_we) as named constants, shared with the decode stage.
- Split into one sub-module, `sat_counter` (parameterized width, increment enable, synchronous clear), instantiated twice.
- Hazard detection and the FSM stay inline.

## Test plan
- **Load-use:** i_idex_ctrl = lw (REG_we=1, MemtoReg=1, MEM_we=0), rd = 5, rs1 = 5 → one cycle of pc/ifid stall and idex_flush. o_stall_cnt = 1.
- **rd = x0:** same as above with rd = 0 and rs1 = 0 → no stall.
- **Redirect with load-use:** i_ex_redirect = 1 together with a load-use match → ifid_flush = idex_flush = 1, pc_stall = 0. o_flush_cnt increments by 1.
- **Memory wait:** i_mem_req = 1, i_mem_ack arrives 3 cycles later → 3 cycles of full stall plus memwb_flush. o_state goes 0 → 1 → 0.
- **Redirect during wait:** i_ex_redirect held high during the 3-cycle wait → no flush until the ack cycle, then a flush.
- **Timeout:** MEM_TIMEOUT = 4, request never acked → o_mem_err = 1 and o_state = 2 after 5 cycles, outputs stay frozen. A subsequent i_reset returns o_state to 0, clears o_mem_err and clears both counters.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control defines: FSM encodings and ID/EX control-bundle bit positions.
// The bit positions are also used by the decode stage when it packs the bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam int CTRL_W          = 16;
  localparam int CTRL_REG_WE     = 15;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_MEM_WE     = 3;

  // A load writes a register from memory and does not write memory.
  function automatic logic is_load(input logic reg_we, input logic mem_to_reg, input logic mem_we);
    return reg_we & mem_to_reg & ~mem_we;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stage controls between the pipeline datapath and pipe_ctrl.
// master = datapath side (drives hazard info), slave = the controller.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic [4:0]        i_id_rs1_addr;
  logic [4:0]        i_id_rs2_addr;
  logic [4:0]        i_idex_rd_addr;
  logic [CTRL_W-1:0] i_idex_ctrl;
  logic              i_ex_redirect;
  logic              i_mem_req;
  logic              i_mem_ack;

  logic              o_pc_stall;
  logic              o_ifid_stall;
  logic              o_ifid_flush;
  logic              o_idex_stall;
  logic              o_idex_flush;
  logic              o_exmem_stall;
  logic              o_memwb_flush;
  logic              o_mem_err;
  logic [1:0]        o_state;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;

  modport master (
    output i_id_rs1_addr, i_id_rs2_addr, i_idex_rd_addr, i_idex_ctrl,
           i_ex_redirect, i_mem_req, i_mem_ack,
    input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
           o_exmem_stall, o_memwb_flush, o_mem_err, o_state, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_rs1_addr, i_id_rs2_addr, i_idex_rd_addr, i_idex_ctrl,
           i_ex_redirect, i_mem_req, i_mem_ack,
    output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
           o_exmem_stall, o_memwb_flush, o_mem_err, o_state, o_stall_cnt, o_flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Registered output, one cycle from inc to count update.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: load-use, redirect and data-memory wait handling with timeout halt.
// Control outputs are Mealy (same cycle); state, wait counter, error flag and perf counters are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  pipe_ctrl_if.slave    bus
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              mem_err, mem_err_nxt;

  logic load_in_ex, load_use, mem_busy;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush;

  // Only the load-detect bits of the bundle matter here.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{bus.i_idex_ctrl[14:5], bus.i_idex_ctrl[2:0]};

  assign load_in_ex = is_load(bus.i_idex_ctrl[CTRL_REG_WE],
                              bus.i_idex_ctrl[CTRL_MEM_TO_REG],
                              bus.i_idex_ctrl[CTRL_MEM_WE]);

  // rs2 compared for every format: a spurious stall is cheaper than decoding the format here.
  assign load_use = load_in_ex && (bus.i_idex_rd_addr != 5'd0) &&
                    ((bus.i_idex_rd_addr == bus.i_id_rs1_addr) ||
                     (bus.i_idex_rd_addr == bus.i_id_rs2_addr));

  assign mem_busy = bus.i_mem_req & ~bus.i_mem_ack;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    mem_err_nxt = mem_err;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (mem_busy) begin
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = '0;
        end
      end
      ST_MEM_WAIT: begin
        wait_nxt = wait_cnt + WAIT_W'(1);
        if (bus.i_mem_ack) begin
          state_nxt = ST_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = ST_HALT;
          mem_err_nxt = 1'b1;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase

    // Redirect is deliberately ignored under mem_busy: EX is frozen so it re-presents on release.
    if (!i_reset) begin
      if ((state == ST_HALT) || mem_busy) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else if (bus.i_ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  assign bus.o_pc_stall    = pc_stall;
  assign bus.o_ifid_stall  = ifid_stall;
  assign bus.o_ifid_flush  = ifid_flush;
  assign bus.o_idex_stall  = idex_stall;
  assign bus.o_idex_flush  = idex_flush;
  assign bus.o_exmem_stall = exmem_stall;
  assign bus.o_memwb_flush = memwb_flush;
  assign bus.o_mem_err     = mem_err;
  assign bus.o_state       = state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .clr   (i_reset),
    .inc   (pc_stall),
    .count (bus.o_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .clr   (i_reset),
    .inc   (ifid_flush),
    .count (bus.o_flush_cnt)
  );

endmodule
